// File: rtl/instr_sequencer_if.sv
// Sequencer <-> datapath/ROM bundle.
// The master side is the sequencer; the slave side is the datapath plus program ROM.
interface instr_sequencer_if #(
    parameter int PC_W = 5
);
    logic            run;
    logic [22:0]     instr_in;
    logic            rom_en;
    logic [PC_W-1:0] pc;
    logic            data_out;
    logic [7:0]      bus1_buf_en;
    logic [7:0]      bus2_buf_en;
    logic [7:0]      reg_en;
    logic            g_in;
    logic            g_out;
    logic [6:0]      math_enables;
    logic            instr_done;
    logic            halted;
    logic            illegal;

    modport master (
        input  run, instr_in,
        output rom_en, pc, data_out, bus1_buf_en, bus2_buf_en, reg_en,
        output g_in, g_out, math_enables, instr_done, halted, illegal
    );

    modport slave (
        output run, instr_in,
        input  rom_en, pc, data_out, bus1_buf_en, bus2_buf_en, reg_en,
        input  g_in, g_out, math_enables, instr_done, halted, illegal
    );
endinterface

// File: rtl/instr_sequencer.sv
// Multi-cycle control unit: fetch/latch/execute over a synchronous ROM,
// driving register, bus, G and math enables of the simple datapath.
module instr_sequencer #(
    parameter int         PC_W    = 5,
    parameter logic [3:0] HALT_OP = 4'b1111
) (
    input  logic               clk,
    input  logic               reset,
    instr_sequencer_if.master  io
);

    typedef enum logic [2:0] {
        IDLE, FETCH, LATCH, EXEC1, EXEC2, NEXT, HALTED
    } state_t;

    state_t          state, state_nx;
    logic [PC_W-1:0] pc_q;
    logic [9:0]      ir;
    logic            illegal_q;
    logic            set_illegal;

    logic [3:0] func;
    logic [2:0] rx, ry;
    logic [7:0] rx_oh, ry_oh;
    logic       is_halt, is_load, is_move, is_alu;
    logic [6:0] math_code;
    logic       unused_imm;

    // Only func/rx/ry are needed; the immediate goes straight to the datapath.
    assign unused_imm = ^io.instr_in[12:0];

    assign func  = ir[9:6];
    assign rx    = ir[5:3];
    assign ry    = ir[2:0];
    assign rx_oh = 8'b1 << rx;
    assign ry_oh = 8'b1 << ry;

    // Classes are made disjoint so a retuned HALT_OP always wins.
    assign is_halt = func == HALT_OP;
    assign is_load = !is_halt && func == 4'd1;
    assign is_move = !is_halt && func == 4'd2;
    assign is_alu  = !is_halt && func >= 4'd3 && func <= 4'd9;

    always_comb begin
        math_code = 7'b0000000;
        unique case (func)
            4'd3:    math_code = 7'b0100000;
            4'd4:    math_code = 7'b0010000;
            4'd5:    math_code = 7'b1000000;
            4'd6:    math_code = 7'b0000100;
            4'd7:    math_code = 7'b0001000;
            4'd8:    math_code = 7'b0000010;
            4'd9:    math_code = 7'b0000001;
            default: math_code = 7'b0000000;
        endcase
    end

    always_comb begin
        state_nx        = state;
        set_illegal     = 1'b0;
        io.rom_en       = 1'b0;
        io.data_out     = 1'b0;
        io.bus1_buf_en  = 8'h00;
        io.bus2_buf_en  = 8'h00;
        io.reg_en       = 8'h00;
        io.g_in         = 1'b0;
        io.g_out        = 1'b0;
        io.math_enables = 7'b0000000;
        io.instr_done   = 1'b0;
        io.halted       = 1'b0;
        unique case (state)
            IDLE: if (io.run) state_nx = FETCH;
            FETCH: begin
                io.rom_en = 1'b1;
                state_nx  = LATCH;
            end
            LATCH: state_nx = EXEC1;
            EXEC1: begin
                state_nx = NEXT;
                unique case (1'b1)
                    is_halt: state_nx = HALTED;
                    is_load: begin
                        io.data_out = 1'b1;
                        io.reg_en   = rx_oh;
                    end
                    is_move: begin
                        io.bus1_buf_en = ry_oh;
                        io.reg_en      = rx_oh;
                    end
                    is_alu: begin
                        io.bus1_buf_en  = rx_oh;
                        io.bus2_buf_en  = ry_oh;
                        io.g_in         = 1'b1;
                        io.math_enables = math_code;
                        state_nx        = EXEC2;
                    end
                    default: set_illegal = 1'b1;
                endcase
            end
            EXEC2: begin
                io.g_out        = 1'b1;
                io.reg_en       = rx_oh;
                io.math_enables = math_code;
                state_nx        = NEXT;
            end
            NEXT: begin
                io.instr_done = 1'b1;
                state_nx      = io.run ? FETCH : IDLE;
            end
            HALTED: io.halted = 1'b1;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            pc_q      <= '0;
            ir        <= '0;
            illegal_q <= 1'b0;
        end else begin
            state <= state_nx;
            if (state == LATCH) ir <= io.instr_in[22:13];
            if (state == NEXT) pc_q <= pc_q + 1'b1;
            if (set_illegal) illegal_q <= 1'b1;
        end
    end

    assign io.pc      = pc_q;
    assign io.illegal = illegal_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// Bench for instr_sequencer: random programs checked cycle by cycle against
// a per-instruction expected-trace model built from the instruction fields.
module tb_instr_sequencer;

    typedef logic [36:0] vec_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    instr_sequencer_if #(.PC_W(5)) io();

    instr_sequencer #(.PC_W(5), .HALT_OP(4'b1111)) dut (
        .clk   (clk),
        .reset (reset),
        .io    (io.master)
    );

    logic [22:0] rom [32];
    logic [22:0] rom_q = '0;
    always @(posedge clk) if (io.rom_en) rom_q <= rom[io.pc];
    assign io.instr_in = rom_q;

    int passes = 0;
    int total  = 0;
    bit ill_m  = 1'b0;

    task automatic chk(input string tag, input vec_t obs, input vec_t exp);
        total++;
        assert (obs === exp) passes++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    function automatic vec_t obs_vec();
        return {io.rom_en, io.data_out, io.bus1_buf_en, io.bus2_buf_en,
                io.reg_en, io.g_in, io.g_out, io.math_enables,
                io.instr_done, io.halted};
    endfunction

    function automatic vec_t pk(bit re, bit d, logic [7:0] b1, logic [7:0] b2,
                                logic [7:0] rg, bit gi, bit go,
                                logic [6:0] m, bit dn, bit h);
        return {re, d, b1, b2, rg, gi, go, m, dn, h};
    endfunction

    function automatic logic [6:0] mcode(logic [3:0] f);
        case (f)
            4'd3:    return 7'b0100000;
            4'd4:    return 7'b0010000;
            4'd5:    return 7'b1000000;
            4'd6:    return 7'b0000100;
            4'd7:    return 7'b0001000;
            4'd8:    return 7'b0000010;
            4'd9:    return 7'b0000001;
            default: return 7'b0000000;
        endcase
    endfunction

    function automatic bit is_ill(logic [3:0] f);
        return f == 4'd0 || (f >= 4'd10 && f <= 4'd14);
    endfunction

    function automatic logic [22:0] mk(int f, int rx, int ry);
        return {4'(f), 3'(rx), 3'(ry), 13'($urandom)};
    endfunction

    // One instruction from FETCH onward; optionally drop run or assert
    // reset right after the cycle with the given trace index.
    task automatic run_instr(input int addr, input int drop_at, input int rst_at);
        logic [22:0] ins;
        logic [3:0]  f;
        logic [7:0]  ox, oy;
        vec_t        q[$];
        ins = rom[addr % 32];
        f   = ins[22:19];
        ox  = 8'b1 << ins[18:16];
        oy  = 8'b1 << ins[15:13];
        q.push_back(pk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        q.push_back('0);
        if (f == 4'd1) q.push_back(pk(0, 1, 0, 0, ox, 0, 0, 0, 0, 0));
        else if (f == 4'd2) q.push_back(pk(0, 0, oy, 0, ox, 0, 0, 0, 0, 0));
        else if (f >= 4'd3 && f <= 4'd9) begin
            q.push_back(pk(0, 0, ox, oy, 0, 1, 0, mcode(f), 0, 0));
            q.push_back(pk(0, 0, 0, 0, ox, 0, 1, mcode(f), 0, 0));
        end else q.push_back('0);
        if (f == 4'd15) q.push_back(pk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
        else q.push_back(pk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
        foreach (q[i]) begin
            @(negedge clk);
            chk($sformatf("outs@%0d.%0d", addr, i), obs_vec(), q[i]);
            chk($sformatf("pc@%0d.%0d", addr, i), 37'(io.pc), 37'(addr % 32));
            chk($sformatf("illegal@%0d.%0d", addr, i), 37'(io.illegal), 37'(ill_m));
            if (i == 2 && is_ill(f)) ill_m = 1'b1;
            if (i == drop_at) io.run = 1'b0;
            if (i == rst_at) begin
                reset = 1'b1;
                return;
            end
        end
    endtask

    initial begin
        io.run = 1'b0;
        rom[0] = mk(1, 3, 0);
        rom[1] = mk(3, 2, 5);
        for (int k = 0; k < 6; k++) rom[2+k] = mk(4 + k, 1, 6);
        rom[8] = mk($urandom_range(3, 9), $urandom_range(0, 7), $urandom_range(0, 7));
        for (int k = 9; k < 14; k++)
            rom[k] = mk($urandom_range(1, 9), $urandom_range(0, 7), $urandom_range(0, 7));
        rom[14] = mk(12, $urandom_range(0, 7), $urandom_range(0, 7));
        rom[15] = mk(15, 0, 0);
        for (int k = 16; k < 32; k++) rom[k] = '0;

        repeat (2) @(negedge clk);
        chk("reset_outs", obs_vec(), '0);
        chk("reset_pc", 37'(io.pc), 37'd0);
        chk("reset_illegal", 37'(io.illegal), 37'd0);
        reset  = 1'b0;
        io.run = 1'b1;

        for (int a = 0; a < 8; a++) run_instr(a, -1, -1);
        run_instr(8, 3, -1);
        for (int k = 0; k < int'($urandom_range(1, 3)); k++) begin
            @(negedge clk);
            chk("drop_idle_outs", obs_vec(), '0);
            chk("drop_idle_pc", 37'(io.pc), 37'd9);
        end
        io.run = 1'b1;
        for (int a = 9; a < 16; a++) run_instr(a, -1, -1);
        for (int k = 0; k < 6; k++) begin
            io.run = 1'($urandom);
            @(negedge clk);
            chk("halt_outs", obs_vec(), pk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
            chk("halt_pc", 37'(io.pc), 37'd15);
            chk("halt_illegal", 37'(io.illegal), 37'd1);
        end

        reset = 1'b1;
        @(negedge clk);
        ill_m = 1'b0;
        chk("rst2_outs", obs_vec(), '0);
        chk("rst2_pc", 37'(io.pc), 37'd0);
        chk("rst2_illegal", 37'(io.illegal), 37'd0);
        reset  = 1'b0;
        io.run = 1'b1;
        run_instr(0, -1, -1);
        run_instr(1, -1, 2);
        @(negedge clk);
        chk("abort_outs", obs_vec(), '0);
        chk("abort_pc", 37'(io.pc), 37'd0);

        io.run = 1'b0;
        for (int k = 0; k < 32; k++)
            rom[k] = mk($urandom_range(0, 14), $urandom_range(0, 7), $urandom_range(0, 7));
        reset = 1'b0;
        @(negedge clk);
        chk("wrap_idle_outs", obs_vec(), '0);
        io.run = 1'b1;
        for (int n = 0; n < 33; n++) run_instr(n, -1, -1);
        io.run = 1'b0;
        @(negedge clk);
        chk("wrap_end_outs", obs_vec(), '0);
        chk("wrap_end_pc", 37'(io.pc), 37'd1);

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
